// File: rtl/video_sync_gen.sv
// video_sync_gen
//   Composite video timing source clocked at 4 MHz. It produces csync,
//   vsync, burst and field, plus a synthetic target pixel stream that
//   replaces the camera and sync separator in bench and bring-up builds.
//   The target position is programmable at runtime. It is double-buffered,
//   so a new position only takes effect at a field boundary.
//
// Ports
//   clk4mhz      in   4 MHz system clock
//   reset        in   synchronous, active-high reset
//   tgt_load     in   one-cycle strobe; captures the three tgt_*_in values
//   tgt_en_in    in   target enable to capture
//   tgt_line_in  in   [8:0] target top line (v_cnt coordinate)
//   tgt_col_in   in   [8:0] target left column (active-column coordinate)
//   csync        out  composite sync, active-high
//   vsync        out  vertical sync, active-high
//   burst        out  colour-burst gate, active-high
//   field        out  field parity, toggles once per field
//   target       out  high while the scan is inside the target window
//   field_start  out  one-cycle pulse at the start of each field
//   line_cnt     out  [8:0] current v_cnt (debug)
//
// Every output is registered from the current counter values, so every
// output lags the counters by exactly one clock.
module video_sync_gen #(
    parameter int CLKS_PER_LINE   = 254,
    parameter int HSYNC_CLKS      = 19,
    parameter int LINES_PER_FIELD = 262,
    parameter int VSYNC_LINES     = 3,
    parameter int BURST_START     = 22,
    parameter int BURST_CLKS      = 10,
    parameter int TGT_W           = 4,
    parameter int TGT_H           = 3,
    parameter int TGT_LINE_DEF    = 120,
    parameter int TGT_COL_DEF     = 100
) (
    input  logic       clk4mhz,
    input  logic       reset,
    input  logic       tgt_load,
    input  logic       tgt_en_in,
    input  logic [8:0] tgt_line_in,
    input  logic [8:0] tgt_col_in,
    output logic       csync,
    output logic       vsync,
    output logic       burst,
    output logic       field,
    output logic       target,
    output logic       field_start,
    output logic [8:0] line_cnt
);

    // Parameter sanity checks, evaluated at elaboration.
    if (HSYNC_CLKS > BURST_START) begin : gChkBurstStart
        $error("HSYNC_CLKS must not exceed BURST_START");
    end
    if (BURST_START + BURST_CLKS > CLKS_PER_LINE) begin : gChkBurstEnd
        $error("burst must end within the line");
    end
    if (VSYNC_LINES >= LINES_PER_FIELD) begin : gChkVsync
        $error("VSYNC_LINES must be less than LINES_PER_FIELD");
    end
    if (CLKS_PER_LINE > 512 || LINES_PER_FIELD > 512) begin : gChkSize
        $error("line and field lengths must fit 9-bit counters");
    end

    localparam logic [8:0] H_LAST    = 9'(CLKS_PER_LINE - 1);
    localparam logic [8:0] V_LAST    = 9'(LINES_PER_FIELD - 1);
    localparam logic [8:0] HS_END    = 9'(HSYNC_CLKS);
    localparam logic [8:0] BROAD_END = 9'(CLKS_PER_LINE - HSYNC_CLKS);
    localparam logic [8:0] VS_END    = 9'(VSYNC_LINES);
    localparam logic [9:0] BURST_LO  = 10'(BURST_START);
    localparam logic [9:0] BURST_HI  = 10'(BURST_START + BURST_CLKS);
    localparam logic [9:0] TGT_H10   = 10'(TGT_H);
    localparam logic [9:0] TGT_W10   = 10'(TGT_W);
    localparam logic [8:0] LINE_DEF  = 9'(TGT_LINE_DEF);
    localparam logic [8:0] COL_DEF   = 9'(TGT_COL_DEF);

    logic [8:0] hCnt;
    logic [8:0] vCnt;
    logic       fieldCnt;

    logic       pendEn;
    logic [8:0] pendLine;
    logic [8:0] pendCol;
    logic       actEn;
    logic [8:0] actLine;
    logic [8:0] actCol;

    logic       lineEnd;
    logic       fieldEnd;
    logic       vsN;
    logic       csN;
    logic       burstN;
    logic       tgtN;
    logic       fsN;
    logic [8:0] col;
    logic       lineHit;
    logic       colHit;

    assign lineEnd  = (hCnt == H_LAST);
    assign fieldEnd = lineEnd && (vCnt == V_LAST);

    // Raster counters. fieldCnt flips together with the v_cnt wrap.
    always_ff @(posedge clk4mhz) begin
        if (reset) begin
            hCnt     <= '0;
            vCnt     <= '0;
            fieldCnt <= 1'b0;
        end else begin
            hCnt <= lineEnd ? 9'd0 : hCnt + 9'd1;
            if (lineEnd) begin
                vCnt <= fieldEnd ? 9'd0 : vCnt + 9'd1;
            end
            if (fieldEnd) begin
                fieldCnt <= ~fieldCnt;
            end
        end
    end

    // Target double buffer. The active copy loads only on the last clock
    // of a field. A tgt_load in that same clock lands in pending only,
    // because the non-blocking copy reads the old pending value.
    always_ff @(posedge clk4mhz) begin
        if (reset) begin
            pendEn   <= 1'b0;
            pendLine <= LINE_DEF;
            pendCol  <= COL_DEF;
            actEn    <= 1'b0;
            actLine  <= LINE_DEF;
            actCol   <= COL_DEF;
        end else begin
            if (fieldEnd) begin
                actEn   <= pendEn;
                actLine <= pendLine;
                actCol  <= pendCol;
            end
            if (tgt_load) begin
                pendEn   <= tgt_en_in;
                pendLine <= tgt_line_in;
                pendCol  <= tgt_col_in;
            end
        end
    end

    // Next-output decode from the current counter values.
    always_comb begin
        vsN     = (vCnt < VS_END);
        csN     = vsN ? (hCnt < BROAD_END) : (hCnt < HS_END);
        burstN  = !vsN && ({1'b0, hCnt} >= BURST_LO) && ({1'b0, hCnt} < BURST_HI);
        col     = hCnt - HS_END;
        // 10-bit upper bounds, so a window near the line or field end is
        // clipped by the raster instead of wrapping back to column/line 0.
        lineHit = ({1'b0, vCnt} >= {1'b0, actLine}) &&
                  ({1'b0, vCnt} <  {1'b0, actLine} + TGT_H10);
        colHit  = ({1'b0, col} >= {1'b0, actCol}) &&
                  ({1'b0, col} <  {1'b0, actCol} + TGT_W10);
        tgtN    = actEn && !vsN && (hCnt >= HS_END) && lineHit && colHit;
        fsN     = (hCnt == 9'd0) && (vCnt == 9'd0);
    end

    always_ff @(posedge clk4mhz) begin
        if (reset) begin
            csync       <= 1'b0;
            vsync       <= 1'b0;
            burst       <= 1'b0;
            field       <= 1'b0;
            target      <= 1'b0;
            field_start <= 1'b0;
            line_cnt    <= '0;
        end else begin
            csync       <= csN;
            vsync       <= vsN;
            burst       <= burstN;
            field       <= fieldCnt;
            target      <= tgtN;
            field_start <= fsN;
            line_cnt    <= vCnt;
        end
    end

endmodule

// File: tb/tb_video_sync_gen.sv
`timescale 1ns/1ps
module tb_video_sync_gen;

  // Scaled-down raster so that many fields fit in a short run.
  localparam int CPL   = 80;
  localparam int HS    = 8;
  localparam int LPF   = 40;
  localparam int VSL   = 3;
  localparam int BS    = 10;
  localparam int BC    = 5;
  localparam int TW    = 4;
  localparam int TH    = 3;
  localparam int LDEF  = 20;
  localparam int CDEF  = 30;
  localparam int FRAME = CPL * LPF;

  logic       clk4mhz;
  logic       reset;
  logic       tgt_load;
  logic       tgt_en_in;
  logic [8:0] tgt_line_in;
  logic [8:0] tgt_col_in;
  logic       csync;
  logic       vsync;
  logic       burst;
  logic       field;
  logic       target;
  logic       field_start;
  logic [8:0] line_cnt;

  video_sync_gen #(
    .CLKS_PER_LINE(CPL), .HSYNC_CLKS(HS), .LINES_PER_FIELD(LPF),
    .VSYNC_LINES(VSL), .BURST_START(BS), .BURST_CLKS(BC),
    .TGT_W(TW), .TGT_H(TH), .TGT_LINE_DEF(LDEF), .TGT_COL_DEF(CDEF)
  ) dut (
    .clk4mhz(clk4mhz), .reset(reset), .tgt_load(tgt_load),
    .tgt_en_in(tgt_en_in), .tgt_line_in(tgt_line_in), .tgt_col_in(tgt_col_in),
    .csync(csync), .vsync(vsync), .burst(burst), .field(field),
    .target(target), .field_start(field_start), .line_cnt(line_cnt)
  );

  // clock / reset
  initial clk4mhz = 1'b0;
  always #125 clk4mhz = ~clk4mhz;

  // reference model state: s = clocks since reset release
  int n_cmp;
  int n_fail;
  int s;
  int cyc;
  int last_fs;
  int tgt_seen;
  int vs_seen;
  int fs_seen;
  bit m_act_en, m_pend_en;
  int m_act_line, m_pend_line, m_act_col, m_pend_col;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d, want %0d (model state %0d)", tag, obs, exp, s);
    end
  endtask

  // One clock: drive inputs, predict outputs, clock, then compare.
  task automatic tick(input bit rst, input bit ld, input bit en, input int line, input int col);
    int h, v, c;
    bit e_cs, e_vs, e_bu, e_fd, e_tg, e_fs;
    int e_lc;
    reset       = rst;
    tgt_load    = ld;
    tgt_en_in   = en;
    tgt_line_in = 9'(line);
    tgt_col_in  = 9'(col);
    if (rst) begin
      {e_cs, e_vs, e_bu, e_fd, e_tg, e_fs} = '0;
      e_lc = 0;
      s = 0;
      last_fs = -1;
      m_act_en = 0; m_pend_en = 0;
      m_act_line = LDEF; m_pend_line = LDEF;
      m_act_col = CDEF; m_pend_col = CDEF;
    end else begin
      h = s % CPL;
      v = (s / CPL) % LPF;
      c = h - HS;
      e_vs = (v < VSL);
      e_cs = e_vs ? (h < CPL - HS) : (h < HS);
      e_bu = !e_vs && (h >= BS) && (h < BS + BC);
      e_fd = ((s / FRAME) % 2) == 1;
      e_fs = (s % FRAME) == 0;
      e_tg = m_act_en && !e_vs && (h >= HS) &&
             (v >= m_act_line) && (v < m_act_line + TH) &&
             (c >= m_act_col) && (c < m_act_col + TW);
      e_lc = v;
      if ((s % FRAME) == FRAME - 1) begin
        m_act_en = m_pend_en; m_act_line = m_pend_line; m_act_col = m_pend_col;
      end
      if (ld) begin
        m_pend_en = en; m_pend_line = line % 512; m_pend_col = col % 512;
      end
      s++;
    end
    @(posedge clk4mhz);
    @(negedge clk4mhz);
    tgt_load = 1'b0;
    cyc++;
    check("csync", 32'(csync), 32'(e_cs));
    check("vsync", 32'(vsync), 32'(e_vs));
    check("burst", 32'(burst), 32'(e_bu));
    check("field", 32'(field), 32'(e_fd));
    check("target", 32'(target), 32'(e_tg));
    check("field_start", 32'(field_start), 32'(e_fs));
    check("line_cnt", 32'(line_cnt), 32'(e_lc));
    if (target) tgt_seen++;
    if (vsync) vs_seen++;
    if (field_start) begin
      fs_seen++;
      if (last_fs >= 0) check("fs_period", 32'(cyc - last_fs), 32'(FRAME));
      last_fs = cyc;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0);
  endtask

  // Advance until the next tick samples raster phase ph.
  task automatic run_until(input int ph);
    while ((s % FRAME) != ph) tick(0, 0, 0, 0, 0);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; s = 0; cyc = 0; last_fs = -1;
    tgt_seen = 0; vs_seen = 0; fs_seen = 0;
    reset = 1'b1; tgt_load = 1'b0; tgt_en_in = 1'b0;
    tgt_line_in = '0; tgt_col_in = '0;
    @(negedge clk4mhz);

    // reset state
    repeat (3) tick(1, 0, 0, 0, 0);

    // free-run two fields: vsync width, field_start count and spacing
    vs_seen = 0; fs_seen = 0;
    run(FRAME);
    check("vsync_clks_f0", 32'(vs_seen), 32'(VSL * CPL));
    vs_seen = 0;
    run(FRAME);
    check("vsync_clks_f1", 32'(vs_seen), 32'(VSL * CPL));
    check("fs_count", 32'(fs_seen), 32'(2));

    // mid-field load: nothing this field, 3x4 window from the next
    run($urandom_range(100, FRAME / 2));
    tick(0, 1, 1, LDEF, CDEF);
    tgt_seen = 0;
    run_until(0);
    check("tgt_same_field", 32'(tgt_seen), 32'(0));
    tgt_seen = 0;
    run(FRAME);
    check("tgt_next_field", 32'(tgt_seen), 32'(TH * TW));

    // load in the transfer clock: old window one field, then new one
    run_until(FRAME - 1);
    tick(0, 1, 1, 30, 10);
    tgt_seen = 0;
    run(FRAME);
    check("tgt_old_window", 32'(tgt_seen), 32'(TH * TW));
    tgt_seen = 0;
    run(FRAME);
    check("tgt_new_window", 32'(tgt_seen), 32'(TH * TW));

    // window clipped at line end: 2 columns x 3 lines
    tick(0, 1, 1, 35, CPL - HS - 2);
    run_until(0);
    tgt_seen = 0;
    run(FRAME);
    check("tgt_line_end", 32'(tgt_seen), 32'(2 * TH));

    // window clipped at field end: 4 columns x 2 lines
    tick(0, 1, 1, LPF - 2, 0);
    run_until(0);
    tgt_seen = 0;
    run(FRAME);
    check("tgt_field_end", 32'(tgt_seen), 32'(2 * TW));

    // randomized loads at random times, checked cycle by cycle
    for (int k = 0; k < 6; k++) begin
      run($urandom_range(1, FRAME));
      tick(0, 1, 1'($urandom_range(0, 1)), $urandom_range(0, LPF + 5), $urandom_range(0, CPL));
    end
    run(FRAME);

    // reset mid-field while the target is showing
    tick(0, 1, 1, LDEF, CDEF);
    run_until(0);
    run_until(LDEF * CPL + HS + CDEF + 1);
    tick(1, 0, 0, 0, 0);
    tgt_seen = 0;
    run(2 * FRAME);
    check("tgt_after_reset", 32'(tgt_seen), 32'(0));
    tick(0, 1, 1, LDEF, CDEF);
    tgt_seen = 0;
    run(2 * FRAME);
    check("tgt_reload", 32'(tgt_seen), 32'(TH * TW));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
